// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares a single-port screen BRAM between display reads and capture writes.
// Optional VRAM_ARB_WRITE_FIFO_EN posts capture writes through a 4-entry FIFO.
module vram_port_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 9,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              cap_req,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [DATA_W-1:0] cap_wdata,
    output logic              cap_gnt,
    output logic              cap_starved,
    output logic [ADDR_W-1:0] addr,
    output logic              cs_n,
    output logic              wr_n,
    output logic              rd_n,
    output logic [DATA_W-1:0] bram_data_in,
    input  logic [DATA_W-1:0] bram_data_out
);
    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, WR_REC} state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic [1:0]        r_lat;
    logic              w_go_rd, w_go_wr, w_rd_done;
    logic              w_cap_req;
    logic [ADDR_W-1:0] w_cap_addr;
    logic [DATA_W-1:0] w_cap_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (disp_req && w_cap_req) begin
                    if (r_cnt == 8'(STARVE_MAX)) begin
                        w_state_nxt = WR;
                    end else begin
                        w_state_nxt = RD;
                        w_cnt_nxt   = r_cnt + 8'd1;
                    end
                end else if (disp_req) begin
                    w_state_nxt = RD;
                end else if (w_cap_req) begin
                    w_state_nxt = WR;
                end
            end
            RD:      w_state_nxt = RD_WAIT;
            RD_WAIT: w_state_nxt = (r_lat == 2'(RD_LAT - 1)) ? IDLE : RD_WAIT;
            WR:      w_state_nxt = WR_REC;
            default: w_state_nxt = IDLE;
        endcase
        w_go_rd   = (r_state == IDLE) && (w_state_nxt == RD);
        w_go_wr   = (r_state == IDLE) && (w_state_nxt == WR);
        w_rd_done = (r_state == RD_WAIT) && (w_state_nxt == IDLE);
        if (w_go_wr) w_cnt_nxt = 8'd0;
    end

    // Every BRAM-facing output is registered from the next-state decision.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_lat        <= 2'd0;
            cs_n         <= 1'b1;
            rd_n         <= 1'b1;
            wr_n         <= 1'b1;
            addr         <= '0;
            bram_data_in <= '0;
            disp_gnt     <= 1'b0;
            disp_rvalid  <= 1'b0;
            disp_rdata   <= '0;
            cap_starved  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lat       <= (r_state == RD_WAIT) ? r_lat + 2'd1 : 2'd0;
            cs_n        <= !(w_go_rd || w_go_wr);
            rd_n        <= !w_go_rd;
            wr_n        <= !w_go_wr;
            disp_gnt    <= w_go_rd;
            disp_rvalid <= w_rd_done;
            cap_starved <= (w_cnt_nxt == 8'(STARVE_MAX));
            if (w_go_rd) addr <= disp_addr;
            if (w_go_wr) addr <= w_cap_addr;
            if (w_go_wr) bram_data_in <= w_cap_wdata;
            if (w_rd_done) disp_rdata <= bram_data_out;
        end
    end

`ifdef VRAM_ARB_WRITE_FIFO_EN
    logic [ADDR_W+DATA_W-1:0] r_fifo [4];
    logic [1:0]               r_wp, r_rp;
    logic [2:0]               r_fcnt;
    logic                     w_push;

    assign cap_gnt                   = (r_fcnt != 3'd4);
    assign w_push                    = cap_req && cap_gnt;
    assign w_cap_req                 = (r_fcnt != 3'd0);
    assign {w_cap_addr, w_cap_wdata} = r_fifo[r_rp];

    always_ff @(posedge clk_in) begin
        if (w_push) r_fifo[r_wp] <= {cap_addr, cap_wdata};
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_wp   <= 2'd0;
            r_rp   <= 2'd0;
            r_fcnt <= 3'd0;
        end else begin
            if (w_push) r_wp <= r_wp + 2'd1;
            if (w_go_wr) r_rp <= r_rp + 2'd1;
            r_fcnt <= r_fcnt + 3'(w_push) - 3'(w_go_wr);
        end
    end
`else
    assign w_cap_req   = cap_req;
    assign w_cap_addr  = cap_addr;
    assign w_cap_wdata = cap_wdata;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) cap_gnt <= 1'b0;
        else cap_gnt <= w_go_wr;
    end
`endif
endmodule
